// File: rtl/window_stream_if.sv
// window_stream_if
//   Pixel-in / window-out stream bundle for window_stream_gen.
//   Handshake (both directions): a beat transfers on a rising clock edge
//   where valid & ready are both 1. The producer holds valid and its payload
//   stable until that edge. Valid never waits on ready. Ready may depend
//   combinationally on the consumer's own state.
//   Ports:
//     in_valid/in_ready/in_data/in_sof             upstream pixel stream
//     out_valid/out_ready/out_data/out_sof/out_eof downstream window stream
//   Modports:
//     slave  - the window generator
//     master - the environment that drives pixels and accepts windows
interface window_stream_if #(
  parameter int color_width  = 12,
  parameter int window_width = 3
);
  logic                                                in_valid;
  logic                                                in_ready;
  logic [color_width-1:0]                              in_data;
  logic                                                in_sof;
  logic                                                out_valid;
  logic                                                out_ready;
  logic [window_width*window_width*color_width-1:0]    out_data;
  logic                                                out_sof;
  logic                                                out_eof;

  modport slave (
    input  in_valid, in_data, in_sof, out_ready,
    output in_ready, out_valid, out_data, out_sof, out_eof
  );

  modport master (
    output in_valid, in_data, in_sof, out_ready,
    input  in_ready, out_valid, out_data, out_sof, out_eof
  );
endinterface

// File: rtl/window_stream_gen.sv
// window_stream_gen
//   Streaming N x N neighbourhood generator. Each accepted raster-order
//   pixel produces one window whose bottom-right tap is that pixel. N-1
//   image lines are kept in line buffers, and an N x N register array holds
//   the last N columns.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    window_stream_if.slave (pixel in, window out, valid/ready)
//   Parameters:
//     color_width, window_width (N, odd), image_width, image_height,
//     border_mode (0: every position, out-of-image taps zeroed;
//                  1: only windows fully inside the image)
module window_stream_gen #(
  parameter int color_width  = 12,
  parameter int window_width = 3,
  parameter int image_width  = 640,
  parameter int image_height = 480,
  parameter int border_mode  = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  window_stream_if.slave  bus
);
  localparam int N     = window_width;
  localparam int CW    = color_width;
  localparam int COL_W = $clog2(image_width);
  localparam int ROW_W = $clog2(image_height);

  typedef logic [COL_W-1:0] col_t;
  typedef logic [ROW_W-1:0] row_t;

  localparam col_t COL_LAST  = col_t'(image_width - 1);
  localparam row_t ROW_LAST  = row_t'(image_height - 1);
  localparam col_t COL_FIRST = col_t'(N - 1);
  localparam row_t ROW_FIRST = row_t'(N - 1);

  // Line k holds the row k+1 lines above the current one, at every column.
  logic [CW-1:0]     lb      [N-1][image_width];
  logic [CW-1:0]     lb_rd   [N-1];
  logic [CW-1:0]     win     [N][N];
  logic [CW-1:0]     win_nxt [N][N];
  logic [N*N*CW-1:0] masked;

  col_t col, cur_col, col_nxt;
  row_t row, cur_row, row_nxt;
  logic accept, emit, first_pos, last_pos;

  // One output register. The input can move whenever that register is
  // empty or is being drained in this cycle.
  assign bus.in_ready = ~bus.out_valid | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    // in_sof forces the current pixel to the frame origin.
    cur_col = bus.in_sof ? '0 : col;
    cur_row = bus.in_sof ? '0 : row;

    for (int k = 0; k < N - 1; k++) begin
      lb_rd[k] = lb[k][cur_col];
    end

    // Shift the window one column left. The new right-hand column is the
    // current column from the oldest line down to the incoming pixel.
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (c < N - 1) begin
          win_nxt[r][c] = win[r][(c < N - 1) ? c + 1 : c];
        end else if (r == N - 1) begin
          win_nxt[r][c] = bus.in_data;
        end else begin
          win_nxt[r][c] = lb_rd[(r < N - 1) ? (N - 2 - r) : 0];
        end
      end
    end

    // Taps above row 0 or left of column 0 are zeroed. Zeroing them also
    // hides line-buffer contents from before reset or from an earlier frame,
    // and stale shift-register columns from the previous line.
    masked = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (int'(cur_row) >= N - 1 - r && int'(cur_col) >= N - 1 - c) begin
          masked[(r*N+c)*CW +: CW] = win_nxt[r][c];
        end
      end
    end

    emit      = (border_mode == 0) || (cur_row >= ROW_FIRST && cur_col >= COL_FIRST);
    first_pos = (border_mode == 0) ? (cur_col == '0 && cur_row == '0)
                                   : (cur_col == COL_FIRST && cur_row == ROW_FIRST);
    last_pos  = (cur_col == COL_LAST) && (cur_row == ROW_LAST);

    if (cur_col == COL_LAST) begin
      col_nxt = '0;
      row_nxt = (cur_row == ROW_LAST) ? '0 : cur_row + row_t'(1);
    end else begin
      col_nxt = cur_col + col_t'(1);
      row_nxt = cur_row;
    end
  end

  // Line buffers are plain RAM with no reset. Reading and shifting happen at
  // the same column in the same cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb[0][cur_col] <= bus.in_data;
      for (int k = 1; k < N - 1; k++) begin
        lb[k][cur_col] <= lb[k-1][cur_col];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col           <= '0;
      row           <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sof   <= 1'b0;
      bus.out_eof   <= 1'b0;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (accept) begin
      col           <= col_nxt;
      row           <= row_nxt;
      win           <= win_nxt;
      bus.out_valid <= emit;
      // Border positions in mode 1 are buffered but produce no window.
      // The last emitted window stays on out_data in that case.
      if (emit) begin
        bus.out_data <= masked;
        bus.out_sof  <= first_pos;
        bus.out_eof  <= last_pos;
      end
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_window_stream_gen.sv
module tb_window_stream_gen;
  localparam int CW = 12;
  localparam int N  = 3;
  localparam int W  = 5;
  localparam int H  = 4;
  localparam int WW = N * N * CW;
  localparam int QW = WW + 2;

  typedef int taps_t [N*N];

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs (mode 0 and mode 1) ----------------
  window_stream_if #(.color_width(CW), .window_width(N)) bus0 ();
  window_stream_if #(.color_width(CW), .window_width(N)) bus1 ();

  window_stream_gen #(.color_width(CW), .window_width(N), .image_width(W),
                      .image_height(H), .border_mode(0))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  window_stream_gen #(.color_width(CW), .window_width(N), .image_width(W),
                      .image_height(H), .border_mode(1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  logic          mode;
  logic          drv_valid;
  logic          drv_sof;
  logic          drv_ready;
  logic [CW-1:0] drv_data;

  assign bus0.in_valid  = drv_valid & ~mode;
  assign bus1.in_valid  = drv_valid & mode;
  assign bus0.in_data   = drv_data;
  assign bus1.in_data   = drv_data;
  assign bus0.in_sof    = drv_sof;
  assign bus1.in_sof    = drv_sof;
  assign bus0.out_ready = mode ? 1'b1 : drv_ready;
  assign bus1.out_ready = mode ? drv_ready : 1'b1;

  logic          mon_in_ready, mon_out_valid, mon_out_sof, mon_out_eof;
  logic [WW-1:0] mon_out_data;
  assign mon_in_ready  = mode ? bus1.in_ready  : bus0.in_ready;
  assign mon_out_valid = mode ? bus1.out_valid : bus0.out_valid;
  assign mon_out_data  = mode ? bus1.out_data  : bus0.out_data;
  assign mon_out_sof   = mode ? bus1.out_sof   : bus0.out_sof;
  assign mon_out_eof   = mode ? bus1.out_eof   : bus0.out_eof;

  // ---------------- scoreboard ----------------
  logic [QW-1:0] exp_q[$];
  logic [QW-1:0] got_q[$];
  int            acc_cyc[$];
  int            n_cmp = 0;
  int            n_err = 0;

  // Collects every window that transfers on the coming edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && mon_out_valid === 1'b1 && drv_ready === 1'b1)
      got_q.push_back({mon_out_data, mon_out_sof, mon_out_eof});
  end

  // ---------------- reference model ----------------
  // Holds the current frame as an image and cuts windows from it by
  // coordinates.
  int img [H][W];
  int m_row = 0;
  int m_col = 0;

  task automatic model_pixel(input logic [CW-1:0] d, input logic s);
    logic [WW-1:0] w;
    int rr, cc;
    bit is_emit, is_sof, is_eof;
    if (s) begin
      m_row = 0;
      m_col = 0;
    end
    img[m_row][m_col] = int'(d);
    if (mode == 1'b0) begin
      is_emit = 1;
      is_sof  = (m_row == 0) && (m_col == 0);
    end else begin
      is_emit = (m_row >= N - 1) && (m_col >= N - 1);
      is_sof  = (m_row == N - 1) && (m_col == N - 1);
    end
    is_eof = (m_row == H - 1) && (m_col == W - 1);
    if (is_emit) begin
      w = '0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          rr = m_row - (N - 1 - i);
          cc = m_col - (N - 1 - j);
          if (rr >= 0 && cc >= 0) w[(i*N+j)*CW +: CW] = CW'(img[rr][cc]);
        end
      end
      exp_q.push_back({w, is_sof, is_eof});
    end
    m_col++;
    if (m_col == W) begin
      m_col = 0;
      m_row++;
      if (m_row == H) m_row = 0;
    end
  endtask

  function automatic logic [WW-1:0] pack_win(input taps_t t);
    logic [WW-1:0] v;
    v = '0;
    for (int k = 0; k < N * N; k++) v[k*CW +: CW] = CW'(t[k]);
    return v;
  endfunction

  function automatic logic [QW-1:0] got_at(input int i);
    if (i >= 0 && i < got_q.size()) return got_q[i];
    return 'x;
  endfunction

  // ---------------- drivers ----------------
  task automatic send_pixel(input logic [CW-1:0] d, input logic s, input bit rnd);
    bit done;
    if (rnd) begin
      repeat ($urandom_range(0, 2)) begin
        drv_valid = 1'b0;
        drv_ready = ($urandom_range(0, 3) != 0);
        @(posedge clk); #1;
      end
    end
    drv_valid = 1'b1;
    drv_data  = d;
    drv_sof   = s;
    done      = 0;
    for (int waited = 0; waited < 50 && !done; waited++) begin
      @(negedge clk);
      if (mon_in_ready === 1'b1) begin
        done = 1;
        acc_cyc.push_back(cyc);
      end
      @(posedge clk); #1;
      if (!done && rnd) drv_ready = ($urandom_range(0, 3) != 0);
    end
    if (done) begin
      model_pixel(d, s);
    end else begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: in_ready stayed 0 for 50 cycles, required 1");
    end
    drv_valid = 1'b0;
    drv_sof   = 1'b0;
  endtask

  task automatic send_frame(input int offset, input bit first_sof, input bit rnd);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        send_pixel(CW'(r * 16 + c + 1 + offset), first_sof && r == 0 && c == 0, rnd);
  endtask

  task automatic drain();
    drv_valid = 1'b0;
    drv_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic start_test(input logic m);
    mode = m;
    drv_ready = 1'b1;
    got_q.delete();
    exp_q.delete();
    acc_cyc.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    drv_valid = 1'b0;
    drv_sof = 1'b0;
    drv_data = '0;
    drv_ready = 1'b1;
    mode = 1'b0;
    #12;
    n_cmp++; if (bus0.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid0: got %b, required 0", bus0.out_valid); end
    n_cmp++; if (bus0.out_data !== '0) begin n_err++; $display("FAIL reset_data0: got %h, required 0", bus0.out_data); end
    n_cmp++; if ({bus0.out_sof, bus0.out_eof} !== 2'b00) begin n_err++; $display("FAIL reset_flags0: got %b, required 00", {bus0.out_sof, bus0.out_eof}); end
    n_cmp++; if (bus0.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready0: got %b, required 1", bus0.in_ready); end
    n_cmp++; if (bus1.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid1: got %b, required 0", bus1.out_valid); end
    n_cmp++; if (bus1.out_data !== '0) begin n_err++; $display("FAIL reset_data1: got %h, required 0", bus1.out_data); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mode0_frame();
    taps_t tv;
    start_test(1'b0);
    send_frame(0, 1, 0);
    drain();
    n_cmp++; if (got_q.size() != 20) begin n_err++; $display("FAIL m0_count: got %0d, required 20", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_at(i) !== exp_q[i]) begin n_err++; $display("FAIL m0_win[%0d]: got %h, required %h", i, got_at(i), exp_q[i]); end
    end
    tv = '{0, 0, 0, 0, 0, 0, 0, 0, 'h01};
    n_cmp++; if (got_at(0) !== {pack_win(tv), 2'b10}) begin n_err++; $display("FAIL m0_origin: got %h, required %h", got_at(0), {pack_win(tv), 2'b10}); end
    tv = '{'h01, 'h02, 'h03, 'h11, 'h12, 'h13, 'h21, 'h22, 'h23};
    n_cmp++; if (got_at(12) !== {pack_win(tv), 2'b00}) begin n_err++; $display("FAIL m0_win22: got %h, required %h", got_at(12), {pack_win(tv), 2'b00}); end
    n_cmp++; if (got_at(19) !== exp_q[19] || got_at(19)[0] !== 1'b1) begin n_err++; $display("FAIL m0_eof: got %h, required eof=1 in %h", got_at(19), exp_q[19]); end
    n_cmp++;
    if (acc_cyc.size() != 20 || acc_cyc[19] - acc_cyc[0] != 19) begin
      n_err++;
      $display("FAIL m0_rate: got %0d accepts over %0d cycles, required 20 over 19", acc_cyc.size(), (acc_cyc.size() > 0) ? acc_cyc[acc_cyc.size()-1] - acc_cyc[0] : -1);
    end
  endtask

  task automatic test_mode1_frame();
    taps_t tv;
    start_test(1'b1);
    send_frame(0, 1, 0);
    drain();
    n_cmp++; if (got_q.size() != 6) begin n_err++; $display("FAIL m1_count: got %0d, required 6", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_at(i) !== exp_q[i]) begin n_err++; $display("FAIL m1_win[%0d]: got %h, required %h", i, got_at(i), exp_q[i]); end
    end
    tv = '{'h01, 'h02, 'h03, 'h11, 'h12, 'h13, 'h21, 'h22, 'h23};
    n_cmp++; if (got_at(0) !== {pack_win(tv), 2'b10}) begin n_err++; $display("FAIL m1_first: got %h, required %h", got_at(0), {pack_win(tv), 2'b10}); end
    tv = '{'h13, 'h14, 'h15, 'h23, 'h24, 'h25, 'h33, 'h34, 'h35};
    n_cmp++; if (got_at(5) !== {pack_win(tv), 2'b01}) begin n_err++; $display("FAIL m1_last: got %h, required %h", got_at(5), {pack_win(tv), 2'b01}); end
  endtask

  task automatic test_backpressure();
    start_test(1'b0);
    for (int i = 0; i <= 8; i++) send_pixel(CW'((i / W) * 16 + (i % W) + 1), i == 0, 0);
    drv_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++; if (mon_in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready[%0d]: got %b, required 0", k, mon_in_ready); end
      n_cmp++;
      if (mon_out_valid !== 1'b1 || {mon_out_data, mon_out_sof, mon_out_eof} !== exp_q[8]) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got v=%b %h, required v=1 %h", k, mon_out_valid, {mon_out_data, mon_out_sof, mon_out_eof}, exp_q[8]);
      end
      @(posedge clk); #1;
    end
    n_cmp++; if (got_q.size() != 8) begin n_err++; $display("FAIL bp_stalled_count: got %0d, required 8", got_q.size()); end
    drv_ready = 1'b1;
    for (int i = 9; i < W * H; i++) send_pixel(CW'((i / W) * 16 + (i % W) + 1), 1'b0, 0);
    drain();
    n_cmp++; if (got_q.size() != 20) begin n_err++; $display("FAIL bp_count: got %0d, required 20", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_at(i) !== exp_q[i]) begin n_err++; $display("FAIL bp_win[%0d]: got %h, required %h", i, got_at(i), exp_q[i]); end
    end
  endtask

  task automatic test_sof_resync();
    taps_t tv;
    start_test(1'b0);
    for (int i = 0; i < 7; i++) send_pixel(CW'((i / W) * 16 + (i % W) + 1), i == 0, 0);
    send_pixel(CW'('h99), 1'b1, 0);
    for (int i = 1; i < W * H; i++) send_pixel(CW'($urandom_range(0, (1 << CW) - 1)), 1'b0, 0);
    drain();
    n_cmp++; if (got_q.size() != 27) begin n_err++; $display("FAIL sof_count: got %0d, required 27", got_q.size()); end
    tv = '{0, 0, 0, 0, 0, 0, 0, 0, 'h99};
    n_cmp++; if (got_at(7) !== {pack_win(tv), 2'b10}) begin n_err++; $display("FAIL sof_origin: got %h, required %h", got_at(7), {pack_win(tv), 2'b10}); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_at(i) !== exp_q[i]) begin n_err++; $display("FAIL sof_win[%0d]: got %h, required %h", i, got_at(i), exp_q[i]); end
    end
  endtask

  task automatic test_async_reset();
    taps_t tv;
    start_test(1'b0);
    for (int i = 0; i < 9; i++) send_pixel(CW'((i / W) * 16 + (i % W) + 1), i == 0, 0);
    drv_ready = 1'b0;
    n_cmp++; if (bus0.out_valid !== 1'b1) begin n_err++; $display("FAIL ar_pending: got %b, required 1", bus0.out_valid); end
    #($urandom_range(0, 7));
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus0.out_valid !== 1'b0) begin n_err++; $display("FAIL ar_valid: got %b, required 0", bus0.out_valid); end
    n_cmp++; if (bus0.out_data !== '0) begin n_err++; $display("FAIL ar_data: got %h, required 0", bus0.out_data); end
    #9;
    rst_n = 1'b1;
    drv_ready = 1'b1;
    @(posedge clk); #1;
    got_q.delete();
    exp_q.delete();
    m_row = 0;
    m_col = 0;
    send_frame(0, 0, 0);
    drain();
    n_cmp++; if (got_q.size() != 20) begin n_err++; $display("FAIL ar_count: got %0d, required 20", got_q.size()); end
    tv = '{0, 0, 0, 0, 0, 0, 0, 0, 'h01};
    n_cmp++; if (got_at(0) !== {pack_win(tv), 2'b10}) begin n_err++; $display("FAIL ar_origin: got %h, required %h", got_at(0), {pack_win(tv), 2'b10}); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_at(i) !== exp_q[i]) begin n_err++; $display("FAIL ar_win[%0d]: got %h, required %h", i, got_at(i), exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    taps_t tv;
    int leak;
    logic [QW-1:0] g;
    start_test(1'b0);
    send_frame(0, 1, 0);
    send_frame('h80, 1, 0);
    drain();
    n_cmp++; if (got_q.size() != 40) begin n_err++; $display("FAIL b2b_count: got %0d, required 40", got_q.size()); end
    tv = '{0, 0, 0, 0, 0, 0, 0, 'h81, 'h82};
    n_cmp++; if (got_at(21) !== {pack_win(tv), 2'b00}) begin n_err++; $display("FAIL b2b_f2_01: got %h, required %h", got_at(21), {pack_win(tv), 2'b00}); end
    leak = 0;
    for (int i = 20; i < 40; i++) begin
      g = got_at(i);
      for (int k = 0; k < N * N; k++)
        if (g[2 + k*CW +: CW] !== '0 && g[2 + k*CW +: CW] < CW'('h80)) leak++;
    end
    n_cmp++; if (leak != 0) begin n_err++; $display("FAIL b2b_leak: got %0d frame-1 taps in frame 2, required 0", leak); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_at(i) !== exp_q[i]) begin n_err++; $display("FAIL b2b_win[%0d]: got %h, required %h", i, got_at(i), exp_q[i]); end
    end
  endtask

  task automatic test_random(input logic m);
    start_test(m);
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < W * H; i++)
        send_pixel(CW'($urandom_range(0, (1 << CW) - 1)), i == 0, 1);
    drain();
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL rnd%0d_count: got %0d, required %0d", m, got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_at(i) !== exp_q[i]) begin n_err++; $display("FAIL rnd%0d_win[%0d]: got %h, required %h", m, i, got_at(i), exp_q[i]); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_mode0_frame();
    test_mode1_frame();
    test_backpressure();
    test_sof_resync();
    test_async_reset();
    test_back_to_back();
    test_random(1'b0);
    test_random(1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500000, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
